// File: rtl/dct_row_engine.sv
// dct_row_engine
// Computes one 8-point 1-D DCT row, y[k] = sum_n C[k][n] * x[n], k = 0..7.
// A row of eight pixels is latched on an accepted start. The engine walks the
// cosine ROM row address k = 0..7 and multiplies each returned coefficient row
// against the latched pixels. It then emits eight rounded results, one per cycle.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous reset, active-high
//   start      begin a row (sampled only while idle)
//   din        pixel row, pixel 0 in the MSB byte
//   busy       row in progress (cycle after accept through the done cycle)
//   rom_addr   cosine ROM row address k (registered)
//   rom_data   cosine ROM row, C[k][n] in byte n from the MSB, signed
//   dout       y[k], signed 12-bit, rounded half up
//   dout_valid dout / dout_idx valid this cycle
//   dout_idx   k of the current dout
//   done       one-cycle pulse alongside the k = 7 output
module dct_row_engine #(
    parameter bit LEVEL_SHIFT = 1'b1,
    parameter int ROM_LAT     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] din,
    output logic        busy,
    output logic [2:0]  rom_addr,
    input  logic [63:0] rom_data,
    output logic [11:0] dout,
    output logic        dout_valid,
    output logic [2:0]  dout_idx,
    output logic        done
);

    // state | meaning
    // IDLE  | waiting for start, pixel row may be latched
    // ISSUE | driving rom_addr = 0..7, one address per cycle
    // DRAIN | waiting for the k = 7 result to leave the pipeline
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t state, state_next;
    logic   accept;

    logic [63:0]        pix;
    logic [ROM_LAT-1:0] v_pipe;
    logic [2:0]         k_pipe [ROM_LAT];

    logic signed [8:0]  x_s    [8];
    logic signed [7:0]  c_s    [8];
    logic signed [16:0] prod_c [8];
    logic signed [16:0] prod_r [8];
    logic               a_valid;
    logic [2:0]         a_idx;

    logic signed [19:0] sum;
    logic signed [19:0] rsum;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (rom_addr == 3'd7) state_next = DRAIN;
            end
            DRAIN: begin
                if (done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // rom_addr wraps 7 -> 0 on the last issue, so it rests at 0 while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_addr <= 3'd0;
            pix      <= 64'd0;
        end else begin
            if (state == ISSUE) rom_addr <= rom_addr + 3'd1;
            if (accept)         pix      <= din;
        end
    end

    // Valid/index pipe matching the ROM read latency, so stage A sees the k
    // belonging to the rom_data on its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_pipe <= '0;
            for (int i = 0; i < ROM_LAT; i++) k_pipe[i] <= 3'd0;
        end else begin
            v_pipe[0] <= (state == ISSUE);
            k_pipe[0] <= rom_addr;
            for (int i = 1; i < ROM_LAT; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                k_pipe[i] <= k_pipe[i-1];
            end
        end
    end

    always_comb begin
        for (int n = 0; n < 8; n++) begin
            if (LEVEL_SHIFT)
                x_s[n] = $signed({1'b0, pix[63-8*n -: 8]}) - 9'sd128;
            else
                x_s[n] = $signed({pix[63-8*n], pix[63-8*n -: 8]});
            c_s[n]    = $signed(rom_data[63-8*n -: 8]);
            prod_c[n] = 17'(x_s[n]) * 17'(c_s[n]);
        end
    end

    // Stage A: product register
    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid <= 1'b0;
            a_idx   <= 3'd0;
            for (int n = 0; n < 8; n++) prod_r[n] <= 17'sd0;
        end else begin
            a_valid <= v_pipe[ROM_LAT-1];
            a_idx   <= k_pipe[ROM_LAT-1];
            for (int n = 0; n < 8; n++) prod_r[n] <= prod_c[n];
        end
    end

    // Adder tree plus rounding bias. |sum| stays below 2^17, so taking
    // rsum[19:8] is exact: an arithmetic shift right by 8, already 12 bits.
    always_comb begin
        sum = 20'sd0;
        for (int n = 0; n < 8; n++) sum = sum + 20'(prod_r[n]);
        rsum = sum + 20'sd128;
    end

    // Stage B: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= 12'd0;
            dout_valid <= 1'b0;
            dout_idx   <= 3'd0;
            done       <= 1'b0;
        end else begin
            dout_valid <= a_valid;
            done       <= a_valid && (a_idx == 3'd7);
            if (a_valid) begin
                dout     <= rsum[19:8];
                dout_idx <= a_idx;
            end
        end
    end

endmodule

// File: tb/tb_dct_row_engine.sv
module tb_dct_row_engine;

    localparam int ROM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [63:0] din;
    logic        busy;
    logic [2:0]  rom_addr;
    logic [63:0] rom_data;
    logic [11:0] dout;
    logic        dout_valid;
    logic [2:0]  dout_idx;
    logic        done;

    int checks   = 0;
    int failures = 0;

    typedef logic [7:0][11:0] yvec_t;
    typedef struct {
        logic [63:0] d;
        yvec_t       y;
    } vec_t;
    typedef struct packed {
        logic [2:0]  idx;
        logic [11:0] val;
    } exp_t;

    exp_t exp_q[$];
    vec_t tv[4];

    always #5 clk = ~clk;

    dct_row_engine #(.LEVEL_SHIFT(1'b1), .ROM_LAT(ROM_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .din        (din),
        .busy       (busy),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_idx   (dout_idx),
        .done       (done)
    );

    // Cosine table: round(128*cos(j*pi/16)); DC row uses 91.
    function automatic int cos_mag(input int j);
        case (j)
            0: return 128;
            1: return 126;
            2: return 118;
            3: return 106;
            4: return 91;
            5: return 71;
            6: return 49;
            7: return 25;
            default: return 0;
        endcase
    endfunction

    function automatic int coef(input int k, input int n);
        int m;
        if (k == 0) return 91;
        m = ((2*n + 1) * k) % 32;
        if (m > 16) m = 32 - m;
        if (m < 8) return cos_mag(m);
        if (m == 8) return 0;
        return -cos_mag(16 - m);
    endfunction

    function automatic logic [63:0] rom_row(input logic [2:0] a);
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < 8; n++) r[63-8*n -: 8] = 8'(coef(int'(a), n));
        return r;
    endfunction

    function automatic yvec_t dct_model(input logic [63:0] d);
        yvec_t y;
        for (int k = 0; k < 8; k++) begin
            int s, t, q;
            s = 0;
            for (int n = 0; n < 8; n++)
                s += (int'(d[63-8*n -: 8]) - 128) * coef(k, n);
            t = s + 128;
            q = t / 256;
            if ((t % 256 != 0) && (t < 0)) q -= 1;
            y[k] = 12'(q);
        end
        return y;
    endfunction

    function automatic yvec_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        yvec_t y;
        y[0] = 12'(a0); y[1] = 12'(a1); y[2] = 12'(a2); y[3] = 12'(a3);
        y[4] = 12'(a4); y[5] = 12'(a5); y[6] = 12'(a6); y[7] = 12'(a7);
        return y;
    endfunction

    // ROM model with ROM_LAT cycles of read latency
    logic [2:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= rom_addr;
        for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    always_comb rom_data = rom_row(rom_pipe[ROM_LAT-1]);

    task automatic chk(input string nm, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic push_row(input yvec_t y);
        for (int k = 0; k < 8; k++) exp_q.push_back('{idx: 3'(k), val: y[k]});
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        exp_t e;
        if (dout_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_dout: got idx %0d val %0d expected no output at t=%0t",
                         dout_idx, $signed(dout), $time);
            end else begin
                e = exp_q.pop_front();
                chk("dout_idx", int'(dout_idx), int'(e.idx));
                chk("dout", int'($signed(dout)), int'($signed(e.val)));
                chk("done_on_last", int'(done), int'(e.idx == 3'd7));
            end
        end else if (done) begin
            checks++;
            failures++;
            $display("FAIL done_without_valid: got done=1 expected 0 at t=%0t", $time);
        end
    end

    // One row from an idle engine: start in cycle 0, checks through cycle 13.
    task automatic run_row(input logic [63:0] d, input yvec_t y);
        @(posedge clk); #1;
        start = 1'b1;
        din   = d;
        chk("idle_before_start", int'(busy), 0);
        push_row(y);
        for (int c = 1; c <= 13; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                start = 1'b0;
                din   = ~d;
            end
            chk("busy", int'(busy), int'(c <= 12));
            chk("dout_valid", int'(dout_valid), int'(c >= 5 && c <= 12));
            chk("done", int'(done), int'(c == 12));
            if (c <= 8) chk("rom_addr", int'(rom_addr), c - 1);
        end
    endtask

    initial begin
        logic [63:0] d1, d2, d3;

        rst   = 1'b1;
        start = 1'b0;
        din   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_dout", int'(dout), 0);
        chk("rst_dout_valid", int'(dout_valid), 0);
        chk("rst_dout_idx", int'(dout_idx), 0);
        chk("rst_done", int'(done), 0);

        // start together with rst must not be accepted
        start = 1'b1;
        din   = 64'hFF80808080808080;
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", int'(busy), 0);
        repeat (15) @(posedge clk);
        #1;
        chk("rst_start_no_row", exp_q.size(), 0);

        tv[0].d = 64'h8080808080808080; tv[0].y = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tv[1].d = 64'hFFFFFFFFFFFFFFFF; tv[1].y = mk(361, 0, 0, 0, 0, 0, 0, 0);
        tv[2].d = 64'hFF80808080808080; tv[2].y = mk(45, 63, 59, 53, 45, 35, 24, 12);
        tv[3].d = 64'h0080808080808080; tv[3].y = mk(-45, -63, -59, -53, -45, -35, -24, -12);

        for (int i = 0; i < 4; i++) run_row(tv[i].d, tv[i].y);

        for (int i = 0; i < 4; i++) begin
            d1 = {$urandom, $urandom};
            run_row(d1, dct_model(d1));
        end

        // start held high: accepted in cycles 0 and 13 only
        d1 = 64'hFF80808080808080;
        d2 = 64'h0123456789ABCDEF;
        d3 = {$urandom, $urandom};
        @(posedge clk); #1;
        start = 1'b1;
        din   = d1;
        push_row(dct_model(d1));
        push_row(dct_model(d3));
        for (int c = 1; c <= 26; c++) begin
            @(posedge clk); #1;
            start = (c <= 20);
            din   = (c == 13) ? d3 : d2;
            chk("hs_busy", int'(busy), int'((c >= 1 && c <= 12) || (c >= 14 && c <= 25)));
            chk("hs_dout_valid", int'(dout_valid), int'((c >= 5 && c <= 12) || (c >= 18 && c <= 25)));
            chk("hs_done", int'(done), int'(c == 12 || c == 25));
        end
        start = 1'b0;

        // reset in cycle 7 aborts the row
        d1 = 64'h10203040F0E0D0C0;
        @(posedge clk); #1;
        start = 1'b1;
        din   = d1;
        push_row(dct_model(d1));
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) start = 1'b0;
            if (c == 7) rst = 1'b1;
            if (c == 8) begin
                rst = 1'b0;
                chk("abort_busy", int'(busy), 0);
                chk("abort_dout_valid", int'(dout_valid), 0);
                chk("abort_dout", int'(dout), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_dout_idx", int'(dout_idx), 0);
                chk("abort_rom_addr", int'(rom_addr), 0);
                chk("abort_pending", exp_q.size(), 5);
                exp_q.delete();
            end
        end
        d2 = {$urandom, $urandom};
        run_row(d2, dct_model(d2));

        repeat (20) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dct_row_engine.md
Name: dct_row_engine

Overview:
- Computes one 8-point 1-D DCT row: y[k] = sum over n of C[k][n]·x[n], for k = 0..7.
- Sequences the row address of the 8×64-bit cosine ROM (read port 1), consumes the returned coefficient rows, and multiplies each against a latched 64-bit pixel row.
- Emits eight rounded coefficients in order, one per cycle.
- Sits between the pixel/transpose RAM read side and the quantiser / transpose-RAM write side of the DCTQ datapath.

Parameters:
- LEVEL_SHIFT, 1, 1: subtract 128 from each unsigned pixel before multiplying; 0: treat pixel as signed 8-bit, sign-extended to 9 bits.
- ROM_LAT, 2, read latency of the cosine ROM in cycles; aligns the internal valid shift register.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  begin a row; sampled only while busy=0
- din  in  64  pixel row; x[n] = din[63-8n -: 8], pixel 0 in the MSB byte; latched on the accepted start
- busy  out  1  high from the cycle after an accepted start through the cycle done is high
- rom_addr  out  3  cosine ROM row address (k), registered
- rom_data  in  64  ROM row; C[k][n] = rom_data[63-8n -: 8], signed two's complement
- dout  out  12  y[k], signed, rounded
- dout_valid  out  1  dout/dout_idx valid this cycle
- dout_idx  out  3  k of the current dout
- done  out  1  one-cycle pulse coincident with dout_idx=7

Behaviour:
- Reset values: busy=0, rom_addr=0, dout=0, dout_valid=0, dout_idx=0, done=0. State goes to IDLE, the valid pipe is cleared, and the pixel latch is cleared.
- FSM IDLE:
  - start=1 in cycle 0 latches din.
  - Goes to ISSUE; busy=1 from cycle 1.
- FSM ISSUE:
  - rom_addr=k during cycle 1+k, for k = 0..7.
  - After k=7, goes to DRAIN.
- FSM DRAIN:
  - Waits until the output with dout_idx=7 has been driven (cycle 12).
  - Goes to IDLE; busy=0 from cycle 13.
- ROM timing: an address driven in cycle c has its data on rom_data in cycle c+ROM_LAT.
  - A ROM_LAT-deep valid/index shift register tracks each issued k.
- Pipeline stage A: at the end of cycle c+2, register the eight 17-bit signed products. Each product is x[n] (9-bit signed after level shift) times C[k][n] (8-bit signed).
- Pipeline stage B:
  - Adder tree to a 20-bit signed sum s.
  - Round: r = (s + 128) >>> 8, arithmetic shift, i.e. round half up.
  - Register r sign-extended to 12 bits at the end of cycle c+3.
- Latency: start in cycle 0 gives dout_valid in cycles 5..12, with dout_idx = 0..7 contiguous; done=1 in cycle 12.
- Throughput: one row per 13 cycles. The earliest next accepted start is in cycle 13.
- Overflow: |s| ≤ 8·128·127 < 2^17, so no saturation is needed. The 20-bit accumulator is guard headroom only.
- start while busy=1: ignored; the latched din is unchanged.
- start and rst in the same cycle: rst wins; start is not accepted.
- rst mid-row: the next cycle shows all outputs at reset values. No further dout_valid or done occurs for the aborted row, and no stale valid emerges later.
- din changing after acceptance: no effect on the current row.

Test Plan:
- Zero row: din=0x8080808080808080, LEVEL_SHIFT=1, start -> dout_valid in cycles 5..12, dout=0 for all k, done in cycle 12.
- Flat row: din=0xFFFFFFFFFFFFFFFF (x=127) -> y0=361 (8·127·91=92456); y1..y7=0, since each AC row of the ROM sums to zero.
- Impulse positive: din=0xFF80808080808080 -> y0=45, y1=63 (C=0x7E), y3=53 (0x6A), y7=12 (0x19), matching 127·C[k][0] rounded.
- Impulse negative / rounding: din=0x0080808080808080 (x0=-128) -> y0=-45 (exact), y2=-59 (C=0x76; -58.5 rounds to -59 via +128 then >>>8).
- Handshake: start held high in cycles 0..20 -> rows accepted in cycles 0 and 13 only; second-row outputs in cycles 18..25; busy drops only in cycle 26.
- Reset mid-row: rst in cycle 7 -> cycle 8 shows busy=0, dout_valid=0, dout=0, and no done. A new start in cycle 9 produces a full correct row in cycles 14..21.
